// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 memory controller: FSM states,
// default memory geometry and device-register addresses.
package lc3_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

   localparam int          MEM_AW_DEF    = 7;
   localparam logic [15:0] MMIO_BASE_DEF = 16'hFE00;

   // Offsets of the device registers within the MMIO page
   localparam logic [15:0] KBSR_OFS = 16'h0000;
   localparam logic [15:0] KBDR_OFS = 16'h0002;
   localparam logic [15:0] DSR_OFS  = 16'h0004;
   localparam logic [15:0] DDR_OFS  = 16'h0006;

   localparam logic [15:0] KBSR_ADDR = MMIO_BASE_DEF + KBSR_OFS;
   localparam logic [15:0] KBDR_ADDR = MMIO_BASE_DEF + KBDR_OFS;
   localparam logic [15:0] DSR_ADDR  = MMIO_BASE_DEF + DSR_OFS;
   localparam logic [15:0] DDR_ADDR  = MMIO_BASE_DEF + DDR_OFS;

   function automatic logic [15:0] reg_addr(input logic [15:0] base, input logic [15:0] ofs);
      return base + ofs;
   endfunction

endpackage

// File: rtl/lc3_mmio_regs.sv
// LC-3 device registers (KBSR/KBDR/DSR/DDR): address decode, read mux and
// the keyboard-acknowledge / display-write side effects.
module lc3_mmio_regs
   import lc3_pkg::*;
#(
   parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        access,
   input  logic        we,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   input  logic        kbd_valid,
   input  logic [7:0]  kbd_data,
   input  logic        dsp_ready,
   output logic        hit,
   output logic [15:0] rdata,
   output logic        werr,
   output logic        kbd_ack,
   output logic        dsp_valid,
   output logic [7:0]  dsp_data
);

   logic is_kbsr, is_kbdr, is_dsr, is_ddr, fire;

   assign is_kbsr = (addr == reg_addr(MMIO_BASE, KBSR_OFS));
   assign is_kbdr = (addr == reg_addr(MMIO_BASE, KBDR_OFS));
   assign is_dsr  = (addr == reg_addr(MMIO_BASE, DSR_OFS));
   assign is_ddr  = (addr == reg_addr(MMIO_BASE, DDR_OFS));
   assign hit     = is_kbsr | is_kbdr | is_dsr | is_ddr;

   always_comb begin
      rdata = 16'h0000;
      if (is_kbsr)     rdata = {kbd_valid, 15'b0};
      else if (is_kbdr) rdata = {8'h00, kbd_data};
      else if (is_dsr)  rdata = {dsp_ready, 15'b0};
      else if (is_ddr)  rdata = {8'h00, dsp_data};
   end

   // Only a DDR write with the display ready is accepted; every other write is dropped
   assign werr    = ~(is_ddr & dsp_ready);
   assign fire    = access & we & is_ddr & dsp_ready;
   assign kbd_ack = access & ~we & is_kbdr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dsp_valid <= 1'b0;
         dsp_data  <= 8'h00;
      end else begin
         dsp_valid <= fire;
         if (fire) dsp_data <= wdata;
      end
   end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 MAR/MDR memory controller: IDLE/ACCESS/CAPTURE/RESP sequencing onto a
// synchronous RAM. Define LC3_MMIO_EN to add the device-register page.
module lc3_mem_ctrl
   import lc3_pkg::*;
#(
   parameter int          MEM_AW    = MEM_AW_DEF,
   parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [15:0]       req_addr,
   input  logic [15:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [15:0]       rsp_data,
   output logic              rsp_err,
   output logic              mem_we,
   output logic              mem_re,
   output logic [MEM_AW-1:0] mem_waddr,
   output logic [MEM_AW-1:0] mem_raddr,
   output logic [15:0]       mem_d,
   input  logic [15:0]       mem_q,
   input  logic              mem_ready,
   input  logic              kbd_valid,
   input  logic [7:0]        kbd_data,
   output logic              kbd_ack,
   input  logic              dsp_ready,
   output logic              dsp_valid,
   output logic [7:0]        dsp_data
);

   state_t      state, state_nxt;
   logic [15:0] mar, mdr;
   logic        we, err;
   logic        in_access, out_of_range;
   logic        mmio_hit, mmio_werr;
   logic [15:0] mmio_rdata;

   // Strobes are qualified by rst_n so a reset during ACCESS never writes memory
   assign in_access    = (state == ST_ACCESS) & rst_n;
   assign out_of_range = (mar >> MEM_AW) != 16'd0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         mar   <= 16'h0000;
         mdr   <= 16'h0000;
         we    <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  mar <= req_addr;
                  mdr <= req_wdata;
                  we  <= req_we;
                  err <= 1'b0;
               end
            end
            ST_ACCESS: begin
               if (out_of_range) begin
                  if (!mmio_hit || (we && mmio_werr)) err <= 1'b1;
                  else if (!we)                        mdr <= mmio_rdata;
               end
            end
            ST_CAPTURE: begin
               if (!out_of_range) mdr <= mem_q;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_data  = 16'h0000;
      case (state)
         ST_IDLE: begin
            req_ready = rst_n;
            if (req_valid) state_nxt = ST_ACCESS;
         end
         ST_ACCESS:  state_nxt = we ? ST_RESP : ST_CAPTURE;
         ST_CAPTURE: state_nxt = ST_RESP;
         ST_RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = err;
            rsp_data  = err ? 16'h0000 : mdr;
            if (rsp_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign mem_we    = in_access & we & ~out_of_range;
   assign mem_re    = in_access & ~we & ~out_of_range;
   assign mem_waddr = mar[MEM_AW-1:0];
   assign mem_raddr = mar[MEM_AW-1:0];
   assign mem_d     = mdr;

   // The FSM never waits on mem_ready; the memory must always be ready when strobed
   always_ff @(posedge clk) begin
      if (rst_n && (mem_we || mem_re)) assert (mem_ready);
   end

`ifdef LC3_MMIO_EN
   lc3_mmio_regs #(
      .MMIO_BASE (MMIO_BASE)
   ) u_mmio (
      .clk       (clk),
      .rst_n     (rst_n),
      .access    (in_access),
      .we        (we),
      .addr      (mar),
      .wdata     (mdr[7:0]),
      .kbd_valid (kbd_valid),
      .kbd_data  (kbd_data),
      .dsp_ready (dsp_ready),
      .hit       (mmio_hit),
      .rdata     (mmio_rdata),
      .werr      (mmio_werr),
      .kbd_ack   (kbd_ack),
      .dsp_valid (dsp_valid),
      .dsp_data  (dsp_data)
   );
`else
   logic unused_dev;
   assign unused_dev = ^{kbd_valid, kbd_data, dsp_ready};
   assign mmio_hit   = 1'b0;
   assign mmio_werr  = 1'b0;
   assign mmio_rdata = 16'h0000;
   assign kbd_ack    = 1'b0;
   assign dsp_valid  = 1'b0;
   assign dsp_data   = 8'h00;
`endif

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed self-checking bench for lc3_mem_ctrl with a synchronous-RAM model.
module tb_lc3_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [15:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [15:0] rsp_data;
   logic        mem_we, mem_re, mem_ready;
   logic [6:0]  mem_waddr, mem_raddr;
   logic [15:0] mem_d, mem_q;
   logic        kbd_valid, kbd_ack, dsp_ready, dsp_valid;
   logic [7:0]  kbd_data, dsp_data;

   logic [15:0] ram [0:127];

   int tests = 0;
   int fails = 0;
   int pulses, acks, dvs;

   always #5 clk = ~clk;

   lc3_mem_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .mem_we(mem_we), .mem_re(mem_re), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
      .mem_d(mem_d), .mem_q(mem_q), .mem_ready(mem_ready),
      .kbd_valid(kbd_valid), .kbd_data(kbd_data), .kbd_ack(kbd_ack),
      .dsp_ready(dsp_ready), .dsp_valid(dsp_valid), .dsp_data(dsp_data)
   );

   always @(posedge clk) begin
      if (mem_we) ram[mem_waddr] <= mem_d;
      if (mem_re) mem_q <= ram[mem_raddr];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tally();
      if (mem_we || mem_re) pulses++;
      if (kbd_ack) acks++;
      if (dsp_valid) dvs++;
   endtask

   // Issues one access with rsp_ready=1 and returns what was observed.
   task automatic run_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                             output int lat, output logic [15:0] data, output logic err);
      int wc;
      rsp_ready = 1'b1; req_we = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
      wc = 0;
      while (!req_ready && wc < 20) begin step(); wc++; end
      step();
      req_valid = 1'b0;
      lat = 1; pulses = 0; acks = 0; dvs = 0;
      tally();
      while (!rsp_valid && lat < 20) begin step(); lat++; tally(); end
      data = rsp_data; err = rsp_err;
      if (!rsp_valid) begin
         tests++; fails++;
         $display("FAIL rsp_timeout addr=%h got no rsp_valid within 20 cycles", a);
      end
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b1; mem_ready = 1'b1; kbd_valid = 1'b0; kbd_data = '0; dsp_ready = 1'b0;
      repeat (3) step();
      tests++;
      if ({req_ready, rsp_valid, rsp_err, mem_we, mem_re, kbd_ack, dsp_valid} !== 7'b0) begin
         fails++; $display("FAIL reset_ctrl got %b required 0000000",
            {req_ready, rsp_valid, rsp_err, mem_we, mem_re, kbd_ack, dsp_valid});
      end
      tests++;
      if (rsp_data !== 16'h0 || mem_d !== 16'h0 || mem_waddr !== 7'h0 || mem_raddr !== 7'h0 || dsp_data !== 8'h0) begin
         fails++; $display("FAIL reset_data got rsp_data=%h mem_d=%h waddr=%h raddr=%h dsp_data=%h required all 0",
            rsp_data, mem_d, mem_waddr, mem_raddr, dsp_data);
      end
      rst_n = 1'b1;
      #1;
      tests++;
      if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_release req_ready got %b required 1", req_ready); end
   endtask

   task automatic test_write_read();
      rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0005; req_wdata = 16'h1234;
      step(); req_valid = 1'b0;
      tests++;
      if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_waddr !== 7'd5 || mem_d !== 16'h1234 || rsp_valid !== 1'b0) begin
         fails++; $display("FAIL wr_t1 got we=%b re=%b waddr=%h d=%h rv=%b required 1 0 05 1234 0",
            mem_we, mem_re, mem_waddr, mem_d, rsp_valid);
      end
      step();
      tests++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 16'h1234 || mem_we !== 1'b0) begin
         fails++; $display("FAIL wr_t2 got rv=%b err=%b data=%h we=%b required 1 0 1234 0",
            rsp_valid, rsp_err, rsp_data, mem_we);
      end
      step();
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0005; req_wdata = 16'hFFFF;
      tests++;
      if (req_ready !== 1'b1) begin fails++; $display("FAIL wr_idle req_ready got %b required 1", req_ready); end
      step(); req_valid = 1'b0;
      tests++;
      if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_raddr !== 7'd5) begin
         fails++; $display("FAIL rd_t1 got re=%b we=%b raddr=%h required 1 0 05", mem_re, mem_we, mem_raddr);
      end
      step();
      tests++;
      if (rsp_valid !== 1'b0 || mem_re !== 1'b0) begin
         fails++; $display("FAIL rd_t2 got rv=%b re=%b required 0 0", rsp_valid, mem_re);
      end
      step();
      tests++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'h1234 || rsp_err !== 1'b0) begin
         fails++; $display("FAIL rd_t3 got rv=%b data=%h err=%b required 1 1234 0", rsp_valid, rsp_data, rsp_err);
      end
      step();
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0005;
      step(); req_valid = 1'b0;
      step(); step();
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (rsp_valid !== 1'b1 || rsp_data !== 16'h1234 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
            fails++; $display("FAIL hold_%0d got rv=%b data=%h err=%b rr=%b required 1 1234 0 0",
               i, rsp_valid, rsp_data, rsp_err, req_ready);
         end
         step();
      end
      rsp_ready = 1'b1;
      step();
      tests++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         fails++; $display("FAIL hold_release got rr=%b rv=%b required 1 0", req_ready, rsp_valid);
      end
   endtask

   task automatic test_out_of_range();
      int lat; logic [15:0] d; logic e;
      run_access(1'b1, 16'h3000, 16'hBEEF, lat, d, e);
      tests++;
      if (lat != 2 || e !== 1'b1 || d !== 16'h0 || pulses != 0) begin
         fails++; $display("FAIL oor_write got lat=%0d err=%b data=%h pulses=%0d required 2 1 0000 0", lat, e, d, pulses);
      end
      run_access(1'b0, 16'h0080, 16'h0000, lat, d, e);
      tests++;
      if (lat != 3 || e !== 1'b1 || d !== 16'h0 || pulses != 0) begin
         fails++; $display("FAIL oor_read got lat=%0d err=%b data=%h pulses=%0d required 3 1 0000 0", lat, e, d, pulses);
      end
      run_access(1'b0, 16'h007F, 16'h0000, lat, d, e);
      tests++;
      if (lat != 3 || e !== 1'b0 || d !== 16'h0 || pulses != 1) begin
         fails++; $display("FAIL top_word_read got lat=%0d err=%b data=%h pulses=%0d required 3 0 0000 1", lat, e, d, pulses);
      end
   endtask

   task automatic test_abort();
      int lat; logic [15:0] d; logic e;
      run_access(1'b1, 16'h0010, 16'hA5A5, lat, d, e);
      tests++;
      if (e !== 1'b0 || d !== 16'hA5A5) begin
         fails++; $display("FAIL abort_pre got err=%b data=%h required 0 a5a5", e, d);
      end
      req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0010; req_wdata = 16'h5A5A;
      step(); req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      tests++;
      if (mem_we !== 1'b0) begin fails++; $display("FAIL abort_we got %b required 0", mem_we); end
      step();
      rst_n = 1'b1;
      #1;
      tests++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         fails++; $display("FAIL abort_idle got rr=%b rv=%b required 1 0", req_ready, rsp_valid);
      end
      run_access(1'b0, 16'h0010, 16'h0000, lat, d, e);
      tests++;
      if (e !== 1'b0 || d !== 16'hA5A5 || lat != 3) begin
         fails++; $display("FAIL abort_readback got err=%b data=%h lat=%0d required 0 a5a5 3", e, d, lat);
      end
   endtask

   task automatic test_back_to_back(input logic w, input int gap);
      int acc[$];
      rsp_ready = 1'b1; req_valid = 1'b1; req_we = w; req_addr = 16'h007F; req_wdata = 16'h7F7F;
      for (int c = 0; c < 13; c++) begin
         if (req_ready) acc.push_back(c);
         if (!w && rsp_valid) begin
            tests++;
            if (rsp_data !== 16'h7F7F || rsp_err !== 1'b0) begin
               fails++; $display("FAIL b2b_data got data=%h err=%b required 7f7f 0", rsp_data, rsp_err);
            end
         end
         step();
      end
      req_valid = 1'b0;
      repeat (5) step();
      tests++;
      if (acc.size() < 3) begin
         fails++; $display("FAIL b2b_count we=%b got %0d accepts required at least 3", w, acc.size());
      end else if (acc[1] - acc[0] != gap || acc[2] - acc[1] != gap) begin
         fails++; $display("FAIL b2b_gap we=%b got %0d,%0d required %0d", w, acc[1] - acc[0], acc[2] - acc[1], gap);
      end
   endtask

   task automatic test_devices();
      int lat; logic [15:0] d; logic e;
      kbd_valid = 1'b1; kbd_data = 8'h41; dsp_ready = 1'b0;
`ifdef LC3_MMIO_EN
      run_access(1'b0, 16'hFE00, 16'h0000, lat, d, e);
      tests++;
      if (d !== 16'h8000 || e !== 1'b0 || lat != 3 || pulses != 0 || acks != 0) begin
         fails++; $display("FAIL kbsr got data=%h err=%b lat=%0d pulses=%0d acks=%0d required 8000 0 3 0 0", d, e, lat, pulses, acks);
      end
      run_access(1'b0, 16'hFE02, 16'h0000, lat, d, e);
      tests++;
      if (d !== 16'h0041 || e !== 1'b0 || lat != 3 || pulses != 0 || acks != 1) begin
         fails++; $display("FAIL kbdr got data=%h err=%b lat=%0d pulses=%0d acks=%0d required 0041 0 3 0 1", d, e, lat, pulses, acks);
      end
      run_access(1'b1, 16'hFE06, 16'h0042, lat, d, e);
      tests++;
      if (e !== 1'b1 || d !== 16'h0 || lat != 2 || dvs != 0 || pulses != 0) begin
         fails++; $display("FAIL ddr_busy got err=%b data=%h lat=%0d dvs=%0d pulses=%0d required 1 0000 2 0 0", e, d, lat, dvs, pulses);
      end
      dsp_ready = 1'b1;
      run_access(1'b1, 16'hFE06, 16'h0042, lat, d, e);
      tests++;
      if (e !== 1'b0 || d !== 16'h0042 || lat != 2 || dvs != 1 || dsp_data !== 8'h42) begin
         fails++; $display("FAIL ddr_write got err=%b data=%h lat=%0d dvs=%0d dsp_data=%h required 0 0042 2 1 42", e, d, lat, dvs, dsp_data);
      end
`else
      dsp_ready = 1'b1;
      run_access(1'b0, 16'hFE02, 16'h0000, lat, d, e);
      tests++;
      if (e !== 1'b1 || d !== 16'h0 || lat != 3 || pulses != 0 || acks != 0) begin
         fails++; $display("FAIL dev_off_read got err=%b data=%h lat=%0d pulses=%0d acks=%0d required 1 0000 3 0 0", e, d, lat, pulses, acks);
      end
      run_access(1'b1, 16'hFE06, 16'h0042, lat, d, e);
      tests++;
      if (e !== 1'b1 || lat != 2 || dvs != 0 || dsp_data !== 8'h00) begin
         fails++; $display("FAIL dev_off_write got err=%b lat=%0d dvs=%0d dsp_data=%h required 1 2 0 00", e, lat, dvs, dsp_data);
      end
`endif
   endtask

   initial begin
      for (int i = 0; i < 128; i++) ram[i] = 16'h0000;
      mem_q = 16'h0000;
      test_reset();
      test_write_read();
      test_backpressure();
      test_out_of_range();
      test_abort();
      test_back_to_back(1'b1, 3);
      test_back_to_back(1'b0, 4);
      test_devices();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lc3_mem_ctrl.md
LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_AW, default 7, meaning word-address width of the backing memory (depth 2^MEM_AW = 128).
REQ-002 The block SHALL have parameter MMIO_BASE, default 16'hFE00, meaning the base of the device-register page.
REQ-003 The block SHALL have ports clk, in, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, in, 1, synchronous active-low reset.
REQ-005 The block SHALL have ports req_valid in 1, req_ready out 1, req_we in 1, req_addr in 16, req_wdata in 16: the CPU access request (MAR/MDR source).
REQ-006 The block SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out 16, rsp_err out 1: the access response.
REQ-007 The block SHALL have ports mem_we out 1, mem_re out 1, mem_waddr out MEM_AW, mem_raddr out MEM_AW, mem_d out 16, mem_q in 16, mem_ready in 1: the downstream memory port.
REQ-008 The block SHALL have ports kbd_valid in 1, kbd_data in 8, kbd_ack out 1, dsp_ready in 1, dsp_valid out 1, dsp_data out 8: the device side.

Function
REQ-009 The FSM SHALL have states IDLE, ACCESS, CAPTURE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-010 On req_valid&req_ready at edge T, the block SHALL latch MAR<=req_addr, MDR<=req_wdata and WE<=req_we, then go to ACCESS.
REQ-011 In ACCESS, a read SHALL assert mem_re for exactly one cycle with mem_raddr=MAR[MEM_AW-1:0], then go to CAPTURE.
REQ-012 In ACCESS, a write SHALL assert mem_we for exactly one cycle with mem_waddr=MAR[MEM_AW-1:0] and mem_d=MDR, then go to RESP.
REQ-013 In CAPTURE, the block SHALL register MDR<=mem_q, covering the one-cycle synchronous read latency, then go to RESP.
REQ-014 rsp_valid SHALL be 1 in RESP and held with stable rsp_data/rsp_err until rsp_ready; on that handshake the block SHALL go to IDLE.
REQ-015 Read rsp_valid SHALL rise at T+3; write rsp_valid SHALL rise at T+2; back-to-back throughput SHALL be one access per 3 (write) or 4 (read) cycles with rsp_ready held 1.
REQ-016 An address with MAR[15:MEM_AW]!=0 that is not a decoded device register SHALL produce rsp_err=1, rsp_data=0, no mem_we/mem_re pulse, and the same latency as a memory access.
REQ-017 mem_ready SHALL be ignored by the FSM and checked only by assertion: mem_ready=1 in every cycle mem_we|mem_re=1.
REQ-018 rsp_err SHALL be 0 for every successful access, and writes SHALL return rsp_data=MDR.

Reset
REQ-019 While rst_n=0 at an edge, the block SHALL go to IDLE and clear req_ready, rsp_valid, rsp_data, rsp_err, mem_we, mem_re, mem_d, both addresses, kbd_ack, dsp_valid, dsp_data, MAR and MDR.
REQ-020 A reset in ACCESS/CAPTURE/RESP SHALL abort the access: no mem_we pulse after the reset edge and no response for the aborted request; req_ready SHALL be 1 the first cycle after rst_n returns to 1.

Configuration
REQ-021 With LC3_MMIO_EN defined, reads of KBSR (MMIO_BASE) SHALL return {kbd_valid,15'b0}; reads of KBDR (+2) SHALL return {8'h00,kbd_data} and pulse kbd_ack once in ACCESS.
REQ-022 With LC3_MMIO_EN defined, reads of DSR (+4) SHALL return {dsp_ready,15'b0}; a write to DDR (+6) with dsp_ready=1 SHALL set dsp_data=MDR[7:0] and pulse dsp_valid once.
REQ-023 With LC3_MMIO_EN defined, a write to DDR with dsp_ready=0, or to any other MMIO register, SHALL be dropped and return rsp_err=1; MMIO accesses SHALL never drive mem_we/mem_re and SHALL keep REQ-015 latencies.
REQ-024 Without LC3_MMIO_EN, device addresses SHALL follow REQ-016, kbd_ack/dsp_valid/dsp_data SHALL be tied 0, and device inputs SHALL be unused.

Structure
REQ-025 Package lc3_pkg SHALL hold the FSM state enum, MEM_AW default, and the KBSR/KBDR/DSR/DDR address constants.
REQ-026 The device-register decode and KBDR/DDR side effects SHALL be sub-module lc3_mmio_regs, instantiated only under LC3_MMIO_EN.

Verification
REQ-027 Write x1234 to x0005, then read x0005 -> mem_we pulse at T+1 with waddr 5; read rsp_data=x1234 at T+3, rsp_err=0.
REQ-028 Read with rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable for those 5 cycles, req_ready=0 throughout, and IDLE one cycle after rsp_ready=1.
REQ-029 Write to x3000 -> rsp_err=1 at T+2, and no mem_we or mem_re pulse.
REQ-030 MMIO_EN: kbd_valid=1, kbd_data=x41, read xFE00 then xFE02 -> x8000 then x0041, and a single kbd_ack pulse; DDR write with dsp_ready=0 -> rsp_err=1, no dsp_valid.
REQ-031 rst_n=0 in ACCESS of a write to x0010 -> mem_we never asserted, and a subsequent read of x0010 returns its prior value.
